// File: rtl/tagged_lifo.sv
// tagged_lifo: DEPTH-entry LIFO of WIDTH-bit words with a registered read port,
// top-of-stack tag bit (MSB), occupancy and sticky overflow/underflow status.
// Optional build macro TAGGED_LIFO_HWM_EN adds a high-water-mark register;
// without it hwm is tied to 0.
// Ports:
//   clk, rst (async active-low)
//   push/pop/top/clr   requests (clr highest priority, then pop/push, then top)
//   stack_in           data to push
//   stack_out          registered read data (holds until next successful read)
//   is_empty, full     combinational decode of count
//   count              current occupancy
//   top_tag            MSB of the current top entry, 0 when empty
//   overflow/underflow sticky error flags
//   hwm                high-water mark of count
module tagged_lifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    top,
  input  logic                    clr,
  input  logic [WIDTH-1:0]        stack_in,
  output logic [WIDTH-1:0]        stack_out,
  output logic                    is_empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    top_tag,
  output logic                    overflow,
  output logic                    underflow,
  output logic [$clog2(DEPTH):0]  hwm
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] stack_out_nxt;
  logic             top_tag_nxt;
  logic             overflow_nxt;
  logic             underflow_nxt;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    below_idx;
  logic [WIDTH-1:0] top_word;
  logic [WIDTH-1:0] below_word;

  // Status decode straight from the count register
  assign is_empty = (count == '0);
  assign full     = (count == CW'(DEPTH));

  // Current top and the entry beneath it (indices only meaningful when occupied)
  assign top_idx    = AW'(count - CW'(1));
  assign below_idx  = AW'(count - CW'(2));
  assign top_word   = mem[top_idx];
  assign below_word = mem[below_idx];

  // Request decode and next-state computation
  always_comb begin
    count_nxt     = count;
    stack_out_nxt = stack_out;
    top_tag_nxt   = top_tag;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    wr_en         = 1'b0;
    wr_idx        = AW'(count);

    if (clr) begin
      count_nxt     = '0;
      top_tag_nxt   = 1'b0;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end else if (pop) begin
      // pop+top collapses to pop
      if (is_empty) begin
        underflow_nxt = 1'b1;
        if (push) begin
          wr_en       = 1'b1;
          wr_idx      = '0;
          count_nxt   = CW'(1);
          top_tag_nxt = stack_in[WIDTH-1];
        end
      end else if (push) begin
        // Replace: legal even when full
        stack_out_nxt = top_word;
        wr_en         = 1'b1;
        wr_idx        = top_idx;
        top_tag_nxt   = stack_in[WIDTH-1];
      end else begin
        stack_out_nxt = top_word;
        count_nxt     = count - CW'(1);
        top_tag_nxt   = (count == CW'(1)) ? 1'b0 : below_word[WIDTH-1];
      end
    end else begin
      // Peek sees the old top, then any push lands above it
      if (top) begin
        if (is_empty) underflow_nxt = 1'b1;
        else          stack_out_nxt = top_word;
      end
      if (push) begin
        if (full) begin
          overflow_nxt = 1'b1;
        end else begin
          wr_en       = 1'b1;
          wr_idx      = AW'(count);
          count_nxt   = count + CW'(1);
          top_tag_nxt = stack_in[WIDTH-1];
        end
      end
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= stack_in;
  end

  // Control and read-port registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      stack_out <= '0;
      top_tag   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      stack_out <= stack_out_nxt;
      top_tag   <= top_tag_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

`ifdef TAGGED_LIFO_HWM_EN
  // High-water mark tracks the largest occupancy reached since reset/clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hwm <= '0;
    end else if (clr) begin
      hwm <= '0;
    end else if (count_nxt > hwm) begin
      hwm <= count_nxt;
    end
  end
`else
  assign hwm = '0;
`endif

endmodule
